aes_shift_rows_pipe: RTL and testbench

Parametrised, pipelined Rijndael ShiftRows/InvShiftRows engine with a valid/ready stream interface. It supports state widths of NB = 4, 6 or 8 columns, and the direction is selected per transaction. It sits between SubBytes and MixColumns in the encrypt datapath, and between InvSubBytes and AddRoundKey in the decrypt datapath. It replaces the fixed 128-bit combinational shifters in both datapaths.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/aes_shift_rows_perm.sv | 28 ++
 rtl/aes_shift_rows_pipe.sv | 97 +++++++++
 tb/tb_aes_shift_rows_pipe.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and helpers for the Rijndael round datapath.
// Holds the legal column counts and the per-row ShiftRows offsets.
package aes_pkg;

    typedef logic [7:0] aes_byte_t;

    localparam int unsigned NbLegal [3] = '{4, 6, 8};

    function automatic bit nb_is_legal(int unsigned nb);
        for (int i = 0; i < 3; i++) begin
            if (NbLegal[i] == nb) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Rows 2 and 3 shift one extra column for 256-bit blocks.
    function automatic int unsigned shift_offset(int unsigned nb, int unsigned row);
        if (row == 0) return 0;
        if (nb == 8 && row >= 2) return row + 1;
        return row;
    endfunction

endpackage

// File: rtl/aes_shift_rows_perm.sv
// Combinational ShiftRows / InvShiftRows byte permutation for an NB-column state.
// Byte i of the state sits at bits [8i:8i+7]: row i%4, column i/4.
module aes_shift_rows_perm
    import aes_pkg::*;
#(
    parameter int unsigned NB = 4
) (
    input  logic [0:32*NB-1] data,
    input  logic             inv,
    output logic [0:32*NB-1] perm_data
);

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int unsigned S      = shift_offset(NB, r);
            localparam int unsigned FwdCol = (c + S) % NB;
            localparam int unsigned InvCol = (c + NB - S) % NB;

            aes_byte_t fwd_byte;
            aes_byte_t inv_byte;

            assign fwd_byte = data[8*(r + 4*FwdCol) +: 8];
            assign inv_byte = data[8*(r + 4*InvCol) +: 8];
            assign perm_data[8*(r + 4*c) +: 8] = inv ? inv_byte : fwd_byte;
        end
    end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Two-stage valid/ready ShiftRows/InvShiftRows engine; direction chosen per word.
// Optional sideband tag ports are built when SHIFT_ROWS_TAG_EN is defined.
module aes_shift_rows_pipe
    import aes_pkg::*;
#(
    parameter int unsigned NB    = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_inv,
    input  logic [0:32*NB-1] in_data,
`ifdef SHIFT_ROWS_TAG_EN
    input  logic [TAG_W-1:0] in_tag,
    output logic [TAG_W-1:0] out_tag,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:32*NB-1] out_data,
    output logic             busy
);

    if (!nb_is_legal(NB)) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end
    if (TAG_W == 0) begin : g_bad_tag_w
        $error("aes_shift_rows_pipe: TAG_W must be nonzero");
    end

    logic             a_valid_q;
    logic             a_inv_q;
    logic [0:32*NB-1] a_data_q;
    logic             b_valid_q;
    logic [0:32*NB-1] b_data_q;
    logic [0:32*NB-1] perm_data;

    logic in_hs;
    logic a_adv;
    logic b_adv;

    aes_shift_rows_perm #(
        .NB (NB)
    ) u_perm (
        .data      (a_data_q),
        .inv       (a_inv_q),
        .perm_data (perm_data)
    );

    always_comb begin
        b_adv    = !b_valid_q | out_ready;
        a_adv    = a_valid_q & b_adv;
        in_ready = !rst & (!a_valid_q | b_adv);
        in_hs    = in_valid & in_ready;
        // Gated so no output handshake can complete in a reset cycle.
        out_valid = b_valid_q & !rst;
        out_data  = b_data_q;
        busy      = a_valid_q | b_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q <= 1'b0;
            a_inv_q   <= 1'b0;
            a_data_q  <= '0;
            b_valid_q <= 1'b0;
            b_data_q  <= '0;
        end else begin
            if (in_hs) begin
                a_inv_q  <= in_inv;
                a_data_q <= in_data;
            end
            a_valid_q <= in_hs | (a_valid_q & !a_adv);
            if (b_adv) b_valid_q <= a_valid_q;
            if (a_adv) b_data_q  <= perm_data;
        end
    end

`ifdef SHIFT_ROWS_TAG_EN
    logic [TAG_W-1:0] a_tag_q;
    logic [TAG_W-1:0] b_tag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            a_tag_q <= '0;
            b_tag_q <= '0;
        end else begin
            if (in_hs) a_tag_q <= in_tag;
            if (a_adv) b_tag_q <= a_tag_q;
        end
    end

    assign out_tag = b_tag_q;
`endif

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Self-checking bench for aes_shift_rows_pipe (NB=4 main instance, NB=8 side instance).
// Known-answer table, directed corner sequences and a random scoreboard run.
module tb_aes_shift_rows_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, in_inv;
    logic [0:127] in_data;
    logic         out_valid, out_ready, busy;
    logic [0:127] out_data;

    logic         d8_in_valid, d8_in_ready, d8_in_inv;
    logic [0:255] d8_in_data;
    logic         d8_out_valid, d8_out_ready, d8_busy;
    logic [0:255] d8_out_data;

`ifdef SHIFT_ROWS_TAG_EN
    logic [3:0] in_tag, out_tag, d8_in_tag, d8_out_tag;
    assign in_tag    = 4'h0;
    assign d8_in_tag = 4'h0;
`endif

    aes_shift_rows_pipe #(.NB(4), .TAG_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inv    (in_inv),
        .in_data   (in_data),
`ifdef SHIFT_ROWS_TAG_EN
        .in_tag    (in_tag),
        .out_tag   (out_tag),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    aes_shift_rows_pipe #(.NB(8), .TAG_W(4)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (d8_in_valid),
        .in_ready  (d8_in_ready),
        .in_inv    (d8_in_inv),
        .in_data   (d8_in_data),
`ifdef SHIFT_ROWS_TAG_EN
        .in_tag    (d8_in_tag),
        .out_tag   (d8_out_tag),
`endif
        .out_valid (d8_out_valid),
        .out_ready (d8_out_ready),
        .out_data  (d8_out_data),
        .busy      (d8_busy)
    );

    int checks = 0;
    int errors = 0;
    int out_cnt = 0;
    logic [0:127] sb[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: each row is rotated as a queue of bytes.
    function automatic logic [0:255] ref_perm(input int nb, input logic [0:255] d, input logic inv);
        logic [0:255] o;
        logic [7:0]   row[$];
        int           s;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            row = {};
            for (int c = 0; c < nb; c++) row.push_back(d[8*(r + 4*c) +: 8]);
            if (r == 0) s = 0;
            else if (r == 1) s = 1;
            else if (nb == 8) s = r + 1;
            else s = r;
            for (int k = 0; k < s; k++) begin
                if (inv) row.push_front(row.pop_back());
                else row.push_back(row.pop_front());
            end
            for (int c = 0; c < nb; c++) o[8*(r + 4*c) +: 8] = row[c];
        end
        return o;
    endfunction

    function automatic logic [0:127] model4(input logic [0:127] d, input logic inv);
        logic [0:255] t;
        t = ref_perm(4, {d, 128'h0}, inv);
        return t[0:127];
    endfunction

    function automatic logic [0:127] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (in_valid && in_ready) sb.push_back(model4(in_data, in_inv));
            if (out_valid && out_ready) begin
                out_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got unexpected output %h", out_data);
                end else begin
                    check("sb_data", 256'(out_data), 256'(sb.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic         inv;
        logic [0:127] din;
        logic [0:127] dout;
    } vec_t;

    vec_t         tbl[4];
    logic [0:255] orig8, res8;
    logic [0:127] held;
    int           cnt0;
    bit           drained;

    initial begin
        tbl[0] = '{1'b0, 128'hd42711ae_e0bf98f1_b8b45de5_1e415230,
                         128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
        tbl[1] = '{1'b1, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5,
                         128'hd42711ae_e0bf98f1_b8b45de5_1e415230};
        tbl[2] = '{1'b0, 128'h00010203_04050607_08090a0b_0c0d0e0f,
                         128'h00050a0f_04090e03_080d0207_0c01060b};
        tbl[3] = '{1'b1, 128'h00010203_04050607_08090a0b_0c0d0e0f,
                         128'h000d0a07_04010e0b_0805020f_0c090603};

        rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
        d8_in_valid = 1'b0; d8_in_inv = 1'b0; d8_in_data = '0; d8_out_ready = 1'b1;
        tick(); tick();
        check("rst_in_ready", 256'(in_ready), 256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_out_data", 256'(out_data), 256'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 256'(in_ready), 256'(1));

        // Known-answer table with latency check.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_inv = tbl[i].inv; in_data = tbl[i].din;
            tick();
            in_valid = 1'b0;
            check("kat_lat_n1", 256'(out_valid), 256'(0));
            tick();
            check("kat_lat_n2", 256'(out_valid), 256'(1));
            check("kat_data", 256'(out_data), 256'(tbl[i].dout));
            tick();
        end

        // NB=8 forward then inverse round trip.
        for (int i = 0; i < 32; i++) orig8[8*i +: 8] = 8'(i);
        d8_in_valid = 1'b1; d8_in_inv = 1'b0; d8_in_data = orig8;
        tick();
        d8_in_valid = 1'b0;
        tick();
        check("nb8_fwd_valid", 256'(d8_out_valid), 256'(1));
        check("nb8_first_word", 256'(d8_out_data[0:31]), 256'(32'h00050e13));
        check("nb8_fwd_model", 256'(d8_out_data), 256'(ref_perm(8, orig8, 1'b0)));
        res8 = ref_perm(8, orig8, 1'b0);
        tick();
        d8_in_valid = 1'b1; d8_in_inv = 1'b1; d8_in_data = res8;
        tick();
        d8_in_valid = 1'b0;
        tick();
        check("nb8_inv_valid", 256'(d8_out_valid), 256'(1));
        check("nb8_roundtrip", 256'(d8_out_data), 256'(orig8));
        for (int i = 0; i < 4; i++) begin
            tick();
            orig8 = {rnd128(), rnd128()};
            d8_in_valid = 1'b1; d8_in_inv = i[0]; d8_in_data = orig8;
            tick();
            d8_in_valid = 1'b0;
            tick();
            check("nb8_rand", 256'(d8_out_data), 256'(ref_perm(8, orig8, i[0])));
        end

        // Streaming: 16 words, alternating direction, full throughput.
        cnt0 = out_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_inv = i[0]; in_data = rnd128();
            check("stream_in_ready", 256'(in_ready), 256'(1));
            if (i >= 2) check("stream_out_valid", 256'(out_valid), 256'(1));
            tick();
        end
        in_valid = 1'b0;
        check("stream_tail16", 256'(out_valid), 256'(1));
        tick();
        check("stream_tail17", 256'(out_valid), 256'(1));
        tick();
        check("stream_done", 256'(out_valid), 256'(0));
        check("stream_count", 256'(out_cnt - cnt0), 256'(16));
        check("stream_sb_empty", 256'(sb.size()), 256'(0));

        // Backpressure: fill both stages, stall 5 cycles, then release.
        cnt0 = out_cnt;
        out_ready = 1'b0;
        in_valid = 1'b1; in_inv = 1'b0; in_data = rnd128();
        held = model4(in_data, 1'b0);
        tick();
        in_inv = 1'b1; in_data = rnd128();
        tick();
        in_inv = 1'b0; in_data = rnd128();
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready", 256'(in_ready), 256'(0));
            check("bp_out_valid", 256'(out_valid), 256'(1));
            check("bp_out_stable", 256'(out_data), 256'(held));
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("bp_comb_ready", 256'(in_ready), 256'(1));
        tick();
        in_valid = 1'b0;
        drained = 1'b0;
        for (int i = 0; i < 10 && !drained; i++) begin
            if (!busy) drained = 1'b1;
            else tick();
        end
        check("bp_drained", 256'(drained), 256'(1));
        check("bp_count", 256'(out_cnt - cnt0), 256'(3));
        check("bp_sb_empty", 256'(sb.size()), 256'(0));

        // Reset with two words in flight.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = rnd128();
        tick();
        in_data = rnd128();
        tick();
        in_valid = 1'b0;
        check("mid_busy", 256'(busy), 256'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 256'(in_ready), 256'(0));
        tick();
        check("mid_out_valid", 256'(out_valid), 256'(0));
        check("mid_busy_clr", 256'(busy), 256'(0));
        check("mid_in_ready", 256'(in_ready), 256'(0));
        rst = 1'b0;
        #1;
        check("mid_rel_in_ready", 256'(in_ready), 256'(1));
        check("mid_rel_out_valid", 256'(out_valid), 256'(0));
        out_ready = 1'b1;
        tick();

        // Random traffic against the scoreboard.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_inv    = $urandom_range(0, 1) == 1;
            in_data   = rnd128();
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drained = 1'b0;
        for (int i = 0; i < 10 && !drained; i++) begin
            if (!busy) drained = 1'b1;
            else tick();
        end
        tick();
        check("rand_drained", 256'(drained), 256'(1));
        check("rand_sb_empty", 256'(sb.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
